// File: rtl/fft32_pkg.sv
// Shared constants and complex types for the 32-point FFT datapath.
package fft32_pkg;

    localparam int N           = 32;
    localparam int ADDR_W      = 5;
    localparam int DEF_D_W     = 16;
    localparam int DEF_TW_W    = 16;
    localparam int DEF_TW_FRAC = 14;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    typedef struct packed {
        logic signed [DEF_D_W-1:0] re;
        logic signed [DEF_D_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [DEF_TW_W-1:0] re;
        logic signed [DEF_TW_W-1:0] im;
    } tw_t;

endpackage

// File: rtl/fft32_cmul.sv
// Two-stage complex multiplier: S2 registers the four partial products,
// S3 combines, rounds half-up, saturates and registers the result.
module fft32_cmul
    import fft32_pkg::*;
#(
    parameter int D_W     = DEF_D_W,
    parameter int TW_W    = DEF_TW_W,
    parameter int TW_FRAC = DEF_TW_FRAC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     in_vld,
    input  logic signed [D_W-1:0]    in_re,
    input  logic signed [D_W-1:0]    in_im,
    input  logic signed [TW_W-1:0]   tw_re,
    input  logic signed [TW_W-1:0]   tw_im,
    input  logic [ADDR_W-1:0]        in_idx,
    output logic                     out_vld,
    output logic signed [D_W-1:0]    out_re,
    output logic signed [D_W-1:0]    out_im,
    output logic [ADDR_W-1:0]        out_idx,
    output logic                     out_last,
    output logic                     out_sat
);

    localparam int STAGES = 2;
    localparam int P_W    = D_W + TW_W;
    localparam int Y_W    = P_W + 1;

    localparam logic signed [Y_W-1:0] RND   = {{(Y_W-TW_FRAC){1'b0}}, 1'b1, {(TW_FRAC-1){1'b0}}};
    localparam logic signed [Y_W-1:0] MAX_V = {{(Y_W-D_W+1){1'b0}}, {(D_W-1){1'b1}}};
    localparam logic signed [Y_W-1:0] MIN_V = {{(Y_W-D_W+1){1'b1}}, {(D_W-1){1'b0}}};

    logic [STAGES:1]         vld_pipe;
    logic signed [P_W-1:0]   rr, ii, ri, ir;
    logic [ADDR_W-1:0]       idx_s2;
    logic signed [Y_W-1:0]   yr, yi;
    logic signed [D_W-1:0]   re_q, im_q;
    logic                    re_sat, im_sat;

    // Returns {clipped, value}; the shift is arithmetic so negatives round half-up too.
    function automatic logic [D_W:0] rnd_sat(input logic signed [Y_W-1:0] y);
        logic signed [Y_W-1:0] s;
        s = (y + RND) >>> TW_FRAC;
        if (s > MAX_V)
            rnd_sat = {1'b1, MAX_V[D_W-1:0]};
        else if (s < MIN_V)
            rnd_sat = {1'b1, MIN_V[D_W-1:0]};
        else
            rnd_sat = {1'b0, s[D_W-1:0]};
    endfunction

    assign yr = Y_W'(rr) - Y_W'(ii);
    assign yi = Y_W'(ri) + Y_W'(ir);
    assign {re_sat, re_q} = rnd_sat(yr);
    assign {im_sat, im_q} = rnd_sat(yi);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            rr       <= '0;
            ii       <= '0;
            ri       <= '0;
            ir       <= '0;
            idx_s2   <= '0;
            out_re   <= '0;
            out_im   <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
            out_sat  <= 1'b0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[1], in_vld};
            if (in_vld) begin
                rr     <= in_re * tw_re;
                ii     <= in_im * tw_im;
                ri     <= in_re * tw_im;
                ir     <= in_im * tw_re;
                idx_s2 <= in_idx;
            end
            // Output data only moves with a real sample, so bubbles leave it untouched.
            if (vld_pipe[1]) begin
                out_re   <= re_q;
                out_im   <= im_q;
                out_idx  <= idx_s2;
                out_last <= (idx_s2 == LAST_IDX);
                out_sat  <= re_sat | im_sat;
            end
        end
    end

    assign out_vld = vld_pipe[STAGES];

endmodule

// File: rtl/fft32_twiddle_mult.sv
// Twiddle-multiply stage: handshake, per-frame sample counter, twiddle ROM
// addressing and the S1 capture register ahead of the complex multiplier.
module fft32_twiddle_mult
    import fft32_pkg::*;
#(
    parameter int D_W     = DEF_D_W,
    parameter int TW_W    = DEF_TW_W,
    parameter int TW_FRAC = DEF_TW_FRAC
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic signed [D_W-1:0]    IN_RE,
    input  logic signed [D_W-1:0]    IN_IM,
    input  logic [ADDR_W-1:0]        TW_STEP,
    output logic [ADDR_W-1:0]        ADDR,
    input  logic signed [TW_W-1:0]   DATA_RE,
    input  logic signed [TW_W-1:0]   DATA_IM,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic signed [D_W-1:0]    OUT_RE,
    output logic signed [D_W-1:0]    OUT_IM,
    output logic [ADDR_W-1:0]        OUT_IDX,
    output logic                     OUT_LAST,
    output logic                     OUT_SAT
);

    logic                    en, accept, k_first;
    logic [ADDR_W-1:0]       k, acc, step_h, step_eff;

    logic                    s1_vld;
    logic signed [D_W-1:0]   s1_re, s1_im;
    logic signed [TW_W-1:0]  s1_wr, s1_wi;
    logic [ADDR_W-1:0]       s1_idx;

    // Whole pipeline moves together; a full output register that is not being
    // drained freezes every stage, including the input.
    assign en       = !OUT_VALID || OUT_READY;
    assign IN_READY = en;
    assign accept   = IN_VALID && en;

    assign k_first  = (k == '0);
    assign ADDR     = k_first ? '0 : acc;
    assign step_eff = k_first ? TW_STEP : step_h;

    // acc walks k*step mod 32; 5-bit addition wraps on its own.
    always_ff @(posedge CLK) begin
        if (RST) begin
            k      <= '0;
            acc    <= '0;
            step_h <= '0;
        end else if (accept) begin
            if (k_first)
                step_h <= TW_STEP;
            if (k == LAST_IDX) begin
                k   <= '0;
                acc <= '0;
            end else begin
                k   <= k + 1'b1;
                acc <= ADDR + step_eff;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_vld <= 1'b0;
            s1_re  <= '0;
            s1_im  <= '0;
            s1_wr  <= '0;
            s1_wi  <= '0;
            s1_idx <= '0;
        end else if (en) begin
            s1_vld <= accept;
            if (accept) begin
                s1_re  <= IN_RE;
                s1_im  <= IN_IM;
                s1_wr  <= DATA_RE;
                s1_wi  <= DATA_IM;
                s1_idx <= k;
            end
        end
    end

    fft32_cmul #(
        .D_W     (D_W),
        .TW_W    (TW_W),
        .TW_FRAC (TW_FRAC)
    ) u_cmul (
        .clk      (CLK),
        .rst      (RST),
        .en       (en),
        .in_vld   (s1_vld),
        .in_re    (s1_re),
        .in_im    (s1_im),
        .tw_re    (s1_wr),
        .tw_im    (s1_wi),
        .in_idx   (s1_idx),
        .out_vld  (OUT_VALID),
        .out_re   (OUT_RE),
        .out_im   (OUT_IM),
        .out_idx  (OUT_IDX),
        .out_last (OUT_LAST),
        .out_sat  (OUT_SAT)
    );

endmodule

// File: tb/tb_fft32_twiddle_mult.sv
// Directed bench for fft32_twiddle_mult with a ROM model and an output scoreboard.
module tb_fft32_twiddle_mult;
    import fft32_pkg::*;

    logic                CLK = 1'b0;
    logic                RST;
    logic                IN_VALID, IN_READY;
    logic [15:0]         IN_RE, IN_IM;
    logic [ADDR_W-1:0]   TW_STEP, ADDR;
    logic [15:0]         DATA_RE, DATA_IM;
    logic                OUT_VALID, OUT_READY;
    logic [15:0]         OUT_RE, OUT_IM;
    logic [ADDR_W-1:0]   OUT_IDX;
    logic                OUT_LAST, OUT_SAT;

    typedef struct {
        int re;
        int im;
        int idx;
        bit last;
        bit sat;
        bit lat;
        int t;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   rom_re[N];
    int   rom_im[N];
    int   n_assert = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   k_m = 0;
    int   step_m = 0;
    int   stall_left = 0;

    fft32_twiddle_mult dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_RE     (IN_RE),
        .IN_IM     (IN_IM),
        .TW_STEP   (TW_STEP),
        .ADDR      (ADDR),
        .DATA_RE   (DATA_RE),
        .DATA_IM   (DATA_IM),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_RE    (OUT_RE),
        .OUT_IM    (OUT_IM),
        .OUT_IDX   (OUT_IDX),
        .OUT_LAST  (OUT_LAST),
        .OUT_SAT   (OUT_SAT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    assign DATA_RE = 16'(rom_re[ADDR]);
    assign DATA_IM = 16'(rom_im[ADDR]);

    // Downstream ready: drops for stall_left cycles, changed just after the edge.
    always @(posedge CLK) begin
        #1;
        if (stall_left > 0) begin
            OUT_READY = 1'b0;
            stall_left--;
        end else begin
            OUT_READY = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic exp_t model(input int re, input int im, input int a);
        exp_t   e;
        longint yr, yi, r, i;
        yr = longint'(re) * rom_re[a] - longint'(im) * rom_im[a];
        yi = longint'(re) * rom_im[a] + longint'(im) * rom_re[a];
        r  = (yr + 8192) >>> 14;
        i  = (yi + 8192) >>> 14;
        e.sat = (r > 32767) || (r < -32768) || (i > 32767) || (i < -32768);
        e.re  = (r > 32767) ? 32767 : (r < -32768) ? -32768 : int'(r);
        e.im  = (i > 32767) ? 32767 : (i < -32768) ? -32768 : int'(i);
        e.idx = 0;
        e.last = 1'b0;
        e.lat = 1'b0;
        e.t = 0;
        return e;
    endfunction

    task automatic send(input int re, input int im, input int step, input bit lat);
        int   guard;
        int   a;
        exp_t e;
        IN_VALID = 1'b1;
        IN_RE    = 16'(re);
        IN_IM    = 16'(im);
        TW_STEP  = 5'(step);
        #1;
        guard = 0;
        while (IN_READY !== 1'b1 && guard < 100) begin
            @(negedge CLK);
            #1;
            guard++;
        end
        chk("in_ready_wait", (guard < 100), 1);
        if (k_m == 0) step_m = step;
        a = (k_m * step_m) % N;
        chk("addr", ADDR, a);
        e      = model(re, im, a);
        e.idx  = k_m;
        e.last = (k_m == N - 1);
        e.lat  = lat;
        e.t    = cyc;
        q.push_back(e);
        k_m = (k_m + 1) % N;
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    // Scoreboard: head entry must match every cycle OUT_VALID is high, which
    // also proves the outputs hold while stalled; pop on handshake.
    always @(negedge CLK) begin
        if (OUT_VALID === 1'b1) begin
            if (q.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL unexpected_out: observed idx %0d expected no output", OUT_IDX);
            end else begin
                mon_e = q[0];
                chk("out_re", $signed(OUT_RE), mon_e.re);
                chk("out_im", $signed(OUT_IM), mon_e.im);
                chk("out_idx", OUT_IDX, mon_e.idx);
                chk("out_last", OUT_LAST, mon_e.last);
                chk("out_sat", OUT_SAT, mon_e.sat);
                if (mon_e.lat) begin
                    chk("latency", cyc - mon_e.t, 3);
                    q[0].lat = 1'b0;
                end
                if (OUT_READY !== 1'b1)
                    chk("in_ready_stall", IN_READY, 0);
                else
                    void'(q.pop_front());
            end
        end
    end

    initial begin
        for (int n = 0; n < N; n++) begin
            rom_re[n] = int'(16384.0 * $cos(2.0 * 3.141592653589793 * n / 32.0));
            rom_im[n] = -int'(16384.0 * $sin(2.0 * 3.141592653589793 * n / 32.0));
        end
        RST = 1'b1;
        IN_VALID = 1'b0;
        IN_RE = '0;
        IN_IM = '0;
        TW_STEP = '0;
        OUT_READY = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_out_re", OUT_RE, 0);
        chk("rst_out_im", OUT_IM, 0);
        chk("rst_out_idx", OUT_IDX, 0);
        chk("rst_out_last", OUT_LAST, 0);
        chk("rst_out_sat", OUT_SAT, 0);
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_addr", ADDR, 0);
        RST = 1'b0;
        @(negedge CLK);

        // Identity twiddle, first sample also checks the 3-cycle latency
        for (int k = 0; k < N; k++) send(1000, -200, 0, (k == 0));

        // -j rotation: k=1 lands on ADDR 8 -> (200, -1000)
        for (int k = 0; k < N; k++) begin
            if (k == 1) send(1000, 200, 8, 0);
            else        send(rnd16(), rnd16(), 8, 0);
        end

        // Address wrap with step 3; a new TW_STEP mid-frame must be ignored
        for (int k = 0; k < N; k++) send(rnd16(), rnd16(), (k < 16) ? 3 : 7, 0);
        for (int k = 0; k < N; k++) send(rnd16(), rnd16(), 3, 0);

        // Saturation at ADDR 4 with full-scale input
        for (int k = 0; k < N; k++) begin
            if (k == 4)      send(32767, 32767, 1, 0);
            else if (k == 0) send(-32768, -32768, 1, 0);
            else             send(rnd16(), rnd16(), 1, 0);
        end

        // Backpressure: two 5-cycle stalls inside a continuous stream
        for (int k = 0; k < N; k++) begin
            if (k == 10 || k == 20) stall_left = 5;
            send(rnd16(), rnd16(), 5, 0);
        end

        // Reset mid-frame after 17 samples; in-flight samples are dropped
        for (int k = 0; k < 17; k++) send(rnd16(), rnd16(), 5, 0);
        RST = 1'b1;
        @(negedge CLK);
        chk("midrst_out_valid", OUT_VALID, 0);
        chk("midrst_out_re", OUT_RE, 0);
        chk("midrst_out_im", OUT_IM, 0);
        chk("midrst_out_idx", OUT_IDX, 0);
        chk("midrst_addr", ADDR, 0);
        chk("midrst_in_ready", IN_READY, 1);
        RST = 1'b0;
        q.delete();
        k_m = 0;
        for (int k = 0; k < N; k++) send(rnd16(), rnd16(), 2, (k == 0));

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge CLK);
        chk("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
